s27_scan_seq: RTL and testbench
===============================

# s27_scan_seq

Sequential closure of the s27 benchmark core with a built-in scan access controller. It holds the three state flip-flops (G5, G6, G7) and feeds them back through the s27 next-state logic. It also adds a serial scan chain with a load / capture / unload FSM. This gives the fault-injection and test flow full controllability and observability of the state that the combinational netlist exposes as pseudo-inputs and pseudo-outputs.

## Interface
Parameters:
- CAPTURE_CYCLES, default 1: functional clocks applied between scan load and unload; legal range 1..15.

Ports:
- clock  in  1  single clock; all flops on rising edge.
- reset  in  1  asynchronous, active-high.
- G0, G1, G2, G3  in  1 each  primary inputs.
- test_mode  in  1  0 = functional free-run; 1 = scan controller owns the state flops.
- test_start  in  1  request a scan sequence; sampled only in IDLE with test_mode=1.
- scan_in  in  1  serial scan data.
- scan_out  out  1  serial scan data; equals the G7 flop.
- test_busy  out  1  high in LOAD, RUN, UNLOAD.
- test_done  out  1  one-cycle pulse at sequence end.
- G17  out  1  primary output; combinational from inputs and state.
- state_q  out  3  {G7, G6, G5}.

## Operation
Next-state logic, with n14 = ~G0:
- n15 = ~((G6 & n14) | G3)
- n18 = ~((G6 & n14) | (~G1 & ~G7))
- G17 = n18 | G5 | n15
- n16 = ~(n18 | n15 | G5)
- n11 = ~(n16 | n14)
- n21 = ~((~G7 & ~G1) | G2)

Functional update is G5 <= n11, G6 <= n16, G7 <= n21.

Register behaviour by mode:
- test_mode=0: functional update every clock; FSM held in IDLE.
- test_mode=1 and IDLE: state flops hold.

FSM states: IDLE, LOAD, RUN, UNLOAD, DONE.
- IDLE -> LOAD when test_start=1.
- LOAD: lasts 3 cycles. Each edge shifts G5 <= scan_in, G6 <= G5, G7 <= G6.
- RUN: lasts CAPTURE_CYCLES cycles, one functional update per cycle.
- UNLOAD: lasts 3 cycles with the same shift as LOAD. scan_out shows G7, then G6, then G5 of the captured state. scan_in continues to shift in.
- DONE: one cycle, then IDLE.

Scan ordering:
- Load order: the first bit loaded ends in G7, the second in G6, the third in G5.
- Unload order matches load order.

Boundary behaviour:
- test_start outside IDLE: ignored.
- test_mode falls in any non-IDLE state: FSM goes to IDLE on the next edge and test_done is not pulsed. From that edge on, the state flops resume functional updates from their current contents.
- A 2-bit cycle counter counts LOAD/UNLOAD cycles; a 4-bit counter counts RUN cycles. Both are cleared on every state entry.

## Timing
- Reset values: state 000, FSM IDLE, both counters 0, scan_out 0, test_busy 0, test_done 0. G17 follows its equation; with all inputs at 0 after reset, G17=1.
- test_start sampled at edge E0 (CAPTURE_CYCLES=1):
  - LOAD shifts at E1–E3; the bench drives load bit i in the cycle before edge E(i+1).
  - RUN updates at E4.
  - UNLOAD shifts at E5–E7; scan_out is valid in the cycles before E5, E6 and E7.
  - test_done is high from E7 to E8; IDLE from E8.
- General latency from start to done: 3 + CAPTURE_CYCLES + 3 + 1 edges.
- test_busy rises after E0 and falls at the edge entering DONE.

## Configuration
- S27_CAPTURE_PARITY_EN defined:
  - Adds output capture_parity (1 bit, reset 0).
  - At the edge ending RUN it is loaded with XOR(n11, n16, n21), i.e. the parity of the captured state.
  - It holds until the next RUN completes.
- Macro undefined: the port and its flop are absent; all other behaviour is identical.

## Structure
- Package s27_scan_pkg holds:
  - the FSM state enum {IDLE, LOAD, RUN, UNLOAD, DONE};
  - constant CHAIN_LEN = 3;
  - a localparam for the RUN counter width.
- Sub-module s27_next_state: purely combinational. Inputs are G0–G3 and the state; outputs are G17, n11, n16, n21.
- The top level holds the state flops, the mux between shift and functional update, the FSM and the counters.

## Test plan
- Reset, all inputs 0, test_mode=0, run 5 clocks -> state_q stays 000, G17=1.
- Functional step from state 000 with G0=1, G1=1, G2=0, G3=1 -> after one edge state_q = {G7, G6, G5} = 101; G17=1 before the edge.
- Scan sequence: test_mode=1, pulse test_start, load 0,1,0 (G6=1), inputs G0=0, G1=1, G2=1, G3=0 -> during RUN G17=0; unload yields 0,1,0; test_done pulses exactly at E7–E8; capture_parity=1 when S27_CAPTURE_PARITY_EN is defined.
- test_start asserted in LOAD, RUN and UNLOAD -> no restart; exactly one test_done per accepted start.
- test_mode dropped in RUN cycle 1 -> IDLE next edge, test_busy=0, no test_done; state then updates functionally.
- reset asserted mid-UNLOAD -> immediately state 000, IDLE, test_busy=0, scan_out=0, without waiting for a clock edge.

Source files
------------

// File: rtl/s27_scan_pkg.sv
// Shared types and constants for the s27 sequential core with scan access.
package s27_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    UNLOAD,
    DONE
  } scan_state_e;

  localparam int CHAIN_LEN   = 3;
  localparam int SHIFT_CNT_W = 2;
  localparam int RUN_CNT_W   = 4;

endpackage

// File: rtl/s27_next_state.sv
// Combinational s27 core: primary output G17 and the next-state terms n11/n16/n21.
module s27_next_state (
  input  logic       g0_i,
  input  logic       g1_i,
  input  logic       g2_i,
  input  logic       g3_i,
  input  logic [2:0] state_i,
  output logic       g17_o,
  output logic       n11_o,
  output logic       n16_o,
  output logic       n21_o
);

  logic g5, g6, g7;
  logic n14, n15, n18;

  // state_i is packed {G7, G6, G5}
  assign {g7, g6, g5} = state_i;

  assign n14   = ~g0_i;
  assign n15   = ~((g6 & n14) | g3_i);
  assign n18   = ~((g6 & n14) | (~g1_i & ~g7));
  assign g17_o = n18 | g5 | n15;
  assign n16_o = ~(n18 | n15 | g5);
  assign n11_o = ~(n16_o | n14);
  assign n21_o = ~((~g7 & ~g1_i) | g2_i);

endmodule

// File: rtl/s27_scan_seq.sv
// s27 state flops with a load/run/unload scan controller.
// Optional feature: define S27_CAPTURE_PARITY_EN to add the capture_parity output.
module s27_scan_seq
  import s27_scan_pkg::*;
#(
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       G0,
  input  logic       G1,
  input  logic       G2,
  input  logic       G3,
  input  logic       test_mode,
  input  logic       test_start,
  input  logic       scan_in,
  output logic       scan_out,
  output logic       test_busy,
  output logic       test_done,
  output logic       G17,
  output logic [2:0] state_q
`ifdef S27_CAPTURE_PARITY_EN
  ,
  output logic       capture_parity
`endif
);

  localparam logic [SHIFT_CNT_W-1:0] SHIFT_LAST = SHIFT_CNT_W'(CHAIN_LEN - 1);
  localparam logic [RUN_CNT_W-1:0]   RUN_LAST   = RUN_CNT_W'(CAPTURE_CYCLES - 1);

  scan_state_e            fsm_q, fsm_d;
  logic [2:0]             ff_q, ff_d;
  logic [SHIFT_CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic                   n11, n16, n21;
  logic [2:0]             func_next, shift_next;

  s27_next_state u_core (
    .g0_i    (G0),
    .g1_i    (G1),
    .g2_i    (G2),
    .g3_i    (G3),
    .state_i (ff_q),
    .g17_o   (G17),
    .n11_o   (n11),
    .n16_o   (n16),
    .n21_o   (n21)
  );

  assign func_next  = {n21, n16, n11};
  // Shift toward G7 so the first bit loaded ends up in G7 and leaves first.
  assign shift_next = {ff_q[1], ff_q[0], scan_in};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q       <= IDLE;
      ff_q        <= '0;
      shift_cnt_q <= '0;
      run_cnt_q   <= '0;
    end else begin
      fsm_q       <= fsm_d;
      ff_q        <= ff_d;
      shift_cnt_q <= shift_cnt_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    fsm_d = fsm_q;
    if (!test_mode) begin
      fsm_d = IDLE;
    end else begin
      case (fsm_q)
        IDLE:    if (test_start) fsm_d = LOAD;
        LOAD:    if (shift_cnt_q == SHIFT_LAST) fsm_d = RUN;
        RUN:     if (run_cnt_q == RUN_LAST) fsm_d = UNLOAD;
        UNLOAD:  if (shift_cnt_q == SHIFT_LAST) fsm_d = DONE;
        DONE:    fsm_d = IDLE;
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_cnt_d = '0;
    run_cnt_d   = '0;
    // Counters restart on every state entry.
    if (fsm_d == fsm_q) begin
      if (fsm_q == LOAD || fsm_q == UNLOAD) shift_cnt_d = shift_cnt_q + SHIFT_CNT_W'(1);
      if (fsm_q == RUN)                     run_cnt_d   = run_cnt_q + RUN_CNT_W'(1);
    end

    ff_d = ff_q;
    if (!test_mode) begin
      ff_d = func_next;
    end else begin
      case (fsm_q)
        LOAD, UNLOAD: ff_d = shift_next;
        RUN:          ff_d = func_next;
        default:      ff_d = ff_q;
      endcase
    end
  end

  always_comb begin
    test_busy = (fsm_q == LOAD) || (fsm_q == RUN) || (fsm_q == UNLOAD);
    test_done = (fsm_q == DONE);
    scan_out  = ff_q[2];
    state_q   = ff_q;
  end

`ifdef S27_CAPTURE_PARITY_EN
  logic parity_q, parity_d;

  // Only a RUN that completes into UNLOAD captures; an aborted RUN keeps the old value.
  always_comb begin
    parity_d = parity_q;
    if (fsm_q == RUN && fsm_d == UNLOAD) parity_d = ^func_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  assign capture_parity = parity_q;
`endif

endmodule

// File: tb/tb_s27_scan_seq.sv
// Directed self-checking bench for s27_scan_seq (CAPTURE_CYCLES = 1).
module tb_s27_scan_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       G0, G1, G2, G3;
  logic       test_mode, test_start, scan_in;
  logic       scan_out, test_busy, test_done, G17;
  logic [2:0] state_q;
`ifdef S27_CAPTURE_PARITY_EN
  logic       capture_parity;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  s27_scan_seq #(.CAPTURE_CYCLES(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .G0         (G0),
    .G1         (G1),
    .G2         (G2),
    .G3         (G3),
    .test_mode  (test_mode),
    .test_start (test_start),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .test_busy  (test_busy),
    .test_done  (test_done),
    .G17        (G17),
    .state_q    (state_q)
`ifdef S27_CAPTURE_PARITY_EN
    ,
    .capture_parity (capture_parity)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_g(input logic [3:0] g);
    {G0, G1, G2, G3} = g;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_g(4'b0000);
    test_mode = 1'b0; test_start = 1'b0; scan_in = 1'b0;
    #2;
    step();
    step();
    reset = 1'b0;
    n_cmp++; if (state_q !== 3'b000) begin n_bad++; $display("FAIL reset_state got %b want 000", state_q); end
    n_cmp++; if (test_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", test_busy); end
    n_cmp++; if (test_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", test_done); end
    n_cmp++; if (scan_out !== 1'b0) begin n_bad++; $display("FAIL reset_scan_out got %b want 0", scan_out); end
    n_cmp++; if (G17 !== 1'b1) begin n_bad++; $display("FAIL reset_g17 got %b want 1", G17); end
`ifdef S27_CAPTURE_PARITY_EN
    n_cmp++; if (capture_parity !== 1'b0) begin n_bad++; $display("FAIL reset_parity got %b want 0", capture_parity); end
`endif
    repeat (5) step();
    n_cmp++; if (state_q !== 3'b000) begin n_bad++; $display("FAIL idle_run_state got %b want 000", state_q); end
    n_cmp++; if (G17 !== 1'b1) begin n_bad++; $display("FAIL idle_run_g17 got %b want 1", G17); end
  endtask

  task automatic test_functional();
    set_g(4'b1101);
    #1;
    n_cmp++; if (G17 !== 1'b1) begin n_bad++; $display("FAIL func_g17 got %b want 1", G17); end
    step();
    n_cmp++; if (state_q !== 3'b101) begin n_bad++; $display("FAIL func_step got %b want 101", state_q); end
  endtask

  task automatic test_scan();
    test_mode = 1'b1; test_start = 1'b1;
    step();  // E0
    n_cmp++; if (test_busy !== 1'b1) begin n_bad++; $display("FAIL scan_busy_rise got %b want 1", test_busy); end
    n_cmp++; if (state_q !== 3'b101) begin n_bad++; $display("FAIL scan_idle_hold got %b want 101", state_q); end
    test_start = 1'b0;
    scan_in = 1'b0; step();  // E1
    scan_in = 1'b1; step();  // E2
    scan_in = 1'b0; step();  // E3
    n_cmp++; if (state_q !== 3'b010) begin n_bad++; $display("FAIL scan_loaded got %b want 010", state_q); end
    set_g(4'b0110);
    #1;
    n_cmp++; if (G17 !== 1'b0) begin n_bad++; $display("FAIL scan_run_g17 got %b want 0", G17); end
    step();  // E4
    n_cmp++; if (state_q !== 3'b010) begin n_bad++; $display("FAIL scan_captured got %b want 010", state_q); end
    n_cmp++; if (scan_out !== 1'b0) begin n_bad++; $display("FAIL unload_bit0 got %b want 0", scan_out); end
    scan_in = 1'b1;
    step();  // E5
    n_cmp++; if (scan_out !== 1'b1) begin n_bad++; $display("FAIL unload_bit1 got %b want 1", scan_out); end
    step();  // E6
    n_cmp++; if (scan_out !== 1'b0) begin n_bad++; $display("FAIL unload_bit2 got %b want 0", scan_out); end
    n_cmp++; if (test_done !== 1'b0) begin n_bad++; $display("FAIL done_early got %b want 0", test_done); end
    n_cmp++; if (test_busy !== 1'b1) begin n_bad++; $display("FAIL busy_unload got %b want 1", test_busy); end
    step();  // E7
    n_cmp++; if (test_done !== 1'b1) begin n_bad++; $display("FAIL done_pulse got %b want 1", test_done); end
    n_cmp++; if (test_busy !== 1'b0) begin n_bad++; $display("FAIL busy_fall got %b want 0", test_busy); end
    n_cmp++; if (state_q !== 3'b111) begin n_bad++; $display("FAIL unload_shift_in got %b want 111", state_q); end
`ifdef S27_CAPTURE_PARITY_EN
    n_cmp++; if (capture_parity !== 1'b1) begin n_bad++; $display("FAIL parity_capture got %b want 1", capture_parity); end
`endif
    step();  // E8
    n_cmp++; if (test_done !== 1'b0) begin n_bad++; $display("FAIL done_width got %b want 0", test_done); end
    n_cmp++; if (test_busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_done got %b want 0", test_busy); end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int done_edge = -1;
    scan_in = 1'b0;
    test_start = 1'b1;
    step();  // E0
    for (int i = 1; i <= 20; i++) begin
      step();
      if (test_done === 1'b1) begin
        done_cnt++;
        done_edge = i;
      end
      if (i == 7) test_start = 1'b0;
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL b2b_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (done_edge !== 7) begin n_bad++; $display("FAIL b2b_done_edge got %0d want 7", done_edge); end
    n_cmp++; if (state_q !== 3'b000) begin n_bad++; $display("FAIL b2b_state got %b want 000", state_q); end
`ifdef S27_CAPTURE_PARITY_EN
    n_cmp++; if (capture_parity !== 1'b0) begin n_bad++; $display("FAIL b2b_parity got %b want 0", capture_parity); end
`endif
  endtask

  task automatic test_mode_drop();
    int done_seen = 0;
    test_start = 1'b1;
    step();  // E0
    test_start = 1'b0;
    scan_in = 1'b0; step();
    scan_in = 1'b1; step();
    scan_in = 1'b0; step();  // E3: now in RUN cycle 1
    test_mode = 1'b0;
    step();  // E4
    n_cmp++; if (test_busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy got %b want 0", test_busy); end
    n_cmp++; if (state_q !== 3'b010) begin n_bad++; $display("FAIL drop_state got %b want 010", state_q); end
    if (test_done === 1'b1) done_seen++;
    set_g(4'b1101);
    step();
    n_cmp++; if (state_q !== 3'b101) begin n_bad++; $display("FAIL drop_func_step got %b want 101", state_q); end
    if (test_done === 1'b1) done_seen++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (test_done === 1'b1) done_seen++;
    end
    n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL drop_no_done got %0d want 0", done_seen); end
`ifdef S27_CAPTURE_PARITY_EN
    n_cmp++; if (capture_parity !== 1'b0) begin n_bad++; $display("FAIL drop_parity_hold got %b want 0", capture_parity); end
`endif
  endtask

  task automatic test_reset_mid_unload();
    test_mode = 1'b1; test_start = 1'b1;
    step();  // E0
    test_start = 1'b0;
    scan_in = 1'b1;
    repeat (3) step();  // E1..E3 load 111
    step();  // E4: captures 101, enters UNLOAD
    n_cmp++; if (scan_out !== 1'b1) begin n_bad++; $display("FAIL mid_unload_scan_out got %b want 1", scan_out); end
    n_cmp++; if (test_busy !== 1'b1) begin n_bad++; $display("FAIL mid_unload_busy got %b want 1", test_busy); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (state_q !== 3'b000) begin n_bad++; $display("FAIL async_reset_state got %b want 000", state_q); end
    n_cmp++; if (test_busy !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy got %b want 0", test_busy); end
    n_cmp++; if (scan_out !== 1'b0) begin n_bad++; $display("FAIL async_reset_scan_out got %b want 0", scan_out); end
    n_cmp++; if (test_done !== 1'b0) begin n_bad++; $display("FAIL async_reset_done got %b want 0", test_done); end
    #2;
    reset = 1'b0;
    step();
    n_cmp++; if (test_busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle got %b want 0", test_busy); end
    n_cmp++; if (state_q !== 3'b000) begin n_bad++; $display("FAIL post_reset_hold got %b want 000", state_q); end
  endtask

  initial begin
    test_reset();
    test_functional();
    test_scan();
    test_back_to_back();
    test_mode_drop();
    test_reset_mid_unload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
